// File: rtl/pointwise_psum_collector_pkg.sv
// Shared constants and helpers for the pointwise PE result collector.
// The PE and the collector must agree on these widths and on the pipeline latency.
package pointwise_psum_collector_pkg;

    localparam int PE_DATA_WIDTH   = 16;
    localparam int PSUM_W          = 2 * PE_DATA_WIDTH;
    localparam int PE_PIPE_LATENCY = 3;
    localparam int CHSEL_W         = 8;

    // Index of the last input-channel group; a group count of 0 behaves as 1.
    function automatic logic [CHSEL_W-1:0] last_group_index(input logic [CHSEL_W-1:0] num_groups);
        logic [CHSEL_W-1:0] last_idx;
        if (num_groups == '0) begin
            last_idx = '0;
        end else begin
            last_idx = num_groups - CHSEL_W'(1);
        end
        return last_idx;
    endfunction

endpackage

// File: rtl/pointwise_psum_collector_fifo.sv
// psum_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// Pointers wrap modulo DEPTH; the count separates full from empty. Data is 0 while empty.
module psum_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               push_data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               rd_data_o,
    output logic                           rd_valid_o,
    output logic                           full_o,
    output logic                           drop_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty;
    logic full;
    logic do_push;
    logic do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // A pop frees the slot the simultaneous push writes into, so full+pop still accepts.
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign rd_valid_o = !empty;
    assign full_o     = full;
    assign drop_o     = push_i && full && !do_pop;
    assign count_o    = count_q;

endmodule

// File: rtl/pointwise_psum_collector.sv
// Accumulates PE partial sums per output channel across input-channel groups and queues finished sums.
// Build option: define PSUM_COLLECTOR_RELU_EN to clip negative sums to 0 as they enter the output FIFO.
module pointwise_psum_collector
    import pointwise_psum_collector_pkg::*;
#(
    parameter int DATA_WIDTH             = PE_DATA_WIDTH,
    parameter int OUTCHANNEL_PARALLELISM = 8,
    parameter int FIFO_DEPTH             = 8,
    parameter int PIPE_LATENCY           = PE_PIPE_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHSEL_W-1:0]      num_in_groups,
    input  logic                    psum_valid,
    input  logic [2*DATA_WIDTH-1:0] psum,
    input  logic [CHSEL_W-1:0]      psum_in_sel,
    input  logic [CHSEL_W-1:0]      psum_out_sel,
    output logic                    issue_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic [CHSEL_W-1:0]      out_channel,
    output logic                    overflow
);

    localparam int SUM_W  = 2 * DATA_WIDTH;
    localparam int ENT_W  = $clog2(OUTCHANNEL_PARALLELISM);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_W = SUM_W + CHSEL_W;

    logic [SUM_W-1:0]   acc_q [OUTCHANNEL_PARALLELISM];
    logic [ENT_W-1:0]   entry;
    logic [CHSEL_W-1:0] last_sel;
    logic               is_first;
    logic               is_final;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   push_sum;

    logic               overflow_q, overflow_d;
    logic               issue_ready_q, issue_ready_d;

    logic [FIFO_W-1:0]  fifo_rd_data;
    logic               fifo_rd_valid;
    logic               fifo_full;
    logic               fifo_drop;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_pop;

    assign entry    = psum_out_sel[ENT_W-1:0];
    assign last_sel = last_group_index(num_in_groups);
    assign is_first = (psum_in_sel == '0);
    assign is_final = psum_valid && (psum_in_sel == last_sel);
    assign sum      = is_first ? psum : (acc_q[entry] + psum);

`ifdef PSUM_COLLECTOR_RELU_EN
    // Only the emitted copy is clipped; the accumulator keeps the raw sum.
    assign push_sum = sum[SUM_W-1] ? '0 : sum;
`else
    assign push_sum = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OUTCHANNEL_PARALLELISM; i++) begin
                acc_q[i] <= '0;
            end
        end else if (psum_valid) begin
            acc_q[entry] <= sum;
        end
    end

    assign fifo_pop = fifo_rd_valid && out_ready;

    psum_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (is_final),
        .push_data_i ({push_sum, psum_out_sel}),
        .pop_i       (fifo_pop),
        .rd_data_o   (fifo_rd_data),
        .rd_valid_o  (fifo_rd_valid),
        .full_o      (fifo_full),
        .drop_o      (fifo_drop),
        .count_o     (fifo_count)
    );

    // Based on last cycle's occupancy: the extra slot covers the one-cycle lag of this register,
    // PIPE_LATENCY slots cover operations already inside the PE.
    always_comb begin
        overflow_d    = overflow_q | fifo_drop;
        issue_ready_d = (int'(fifo_count) + PIPE_LATENCY + 1) < FIFO_DEPTH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q    <= 1'b0;
            issue_ready_q <= 1'b1;
        end else begin
            overflow_q    <= overflow_d;
            issue_ready_q <= issue_ready_d;
        end
    end

    assign issue_ready = issue_ready_q;
    assign overflow    = overflow_q;
    assign out_valid   = fifo_rd_valid;
    assign out_data    = fifo_rd_data[FIFO_W-1:CHSEL_W];
    assign out_channel = fifo_rd_data[CHSEL_W-1:0];

endmodule

// File: tb/tb_pointwise_psum_collector.sv
// Bench for pointwise_psum_collector: directed scenarios plus randomized group sequences,
// scored against a channel-sum model with an expected-output queue.
module tb_pointwise_psum_collector;

    localparam int DEPTH = 8;
    localparam int PIPE  = 3;
    localparam int OCP   = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  num_in_groups;
    logic        psum_valid;
    logic [31:0] psum;
    logic [7:0]  psum_in_sel;
    logic [7:0]  psum_out_sel;
    logic        issue_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_channel;
    logic        overflow;

    pointwise_psum_collector dut (
        .clk           (clk),
        .rst           (rst),
        .num_in_groups (num_in_groups),
        .psum_valid    (psum_valid),
        .psum          (psum),
        .psum_in_sel   (psum_in_sel),
        .psum_out_sel  (psum_out_sel),
        .issue_ready   (issue_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_channel   (out_channel),
        .overflow      (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_acc [OCP];
    logic [39:0] exp_q [$];
    bit          m_ovf;
    bit          m_ir;
    int          n_checks;
    int          n_bad;
    int          n_dut_pops;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Applies one clock edge of the behavioural rules to the model.
    task automatic model_edge(input bit v, input logic [31:0] p, input logic [7:0] isel,
                              input logic [7:0] osel, input logic [7:0] grp, input bit rdy);
        int cnt;
        int g;
        int e;
        bit pop;
        logic [31:0] s;
        logic [31:0] ps;
        cnt  = exp_q.size();
        pop  = (cnt > 0) && rdy;
        m_ir = (DEPTH - cnt - 1) > PIPE;
        if (pop) void'(exp_q.pop_front());
        if (v) begin
            e = int'(osel) % OCP;
            g = (grp == 0) ? 1 : int'(grp);
            s = (isel == 0) ? p : m_acc[e] + p;
            m_acc[e] = s;
            if (int'(isel) == g - 1) begin
                ps = s;
`ifdef PSUM_COLLECTOR_RELU_EN
                if (s[31]) ps = 32'd0;
`endif
                if (cnt == DEPTH && !pop) m_ovf = 1'b1;
                else exp_q.push_back({ps, osel});
            end
        end
    endtask

    task automatic compare_outputs();
        chk("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("out_data", out_data, exp_q[0][39:8]);
            chk("out_channel", out_channel, exp_q[0][7:0]);
        end
        chk("overflow", overflow, m_ovf);
        chk("issue_ready", issue_ready, m_ir);
    endtask

    // driver: one cycle of stimulus, model update on the edge, checks on the falling edge
    task automatic step(input bit v, input logic [31:0] p, input logic [7:0] isel,
                        input logic [7:0] osel, input logic [7:0] grp, input bit rdy);
        psum_valid    = v;
        psum          = p;
        psum_in_sel   = isel;
        psum_out_sel  = osel;
        num_in_groups = grp;
        out_ready     = rdy;
        if (out_valid && out_ready) n_dut_pops++;
        @(posedge clk);
        model_edge(v, p, isel, osel, grp, rdy);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 8'd0, 8'd0, 8'd1, rdy);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        psum_valid    = 1'b0;
        psum          = '0;
        psum_in_sel   = '0;
        psum_out_sel  = '0;
        num_in_groups = 8'd1;
        out_ready     = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        for (int i = 0; i < OCP; i++) m_acc[i] = '0;
        m_ovf = 1'b0;
        m_ir  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compare_outputs();
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_channel", out_channel, 8'd0);
    endtask

    initial begin
        bit          pend [PIPE];
        int          n_issued;
        int          n_arrived;
        int          next_in [OCP];
        logic [7:0]  seq_osel [OCP];
        logic [7:0]  grp;
        int          g;
        int          e;

        n_checks   = 0;
        n_bad      = 0;
        n_dut_pops = 0;
        do_reset();

        // single-group pass-through
        step(1'b1, 32'h0000_0005, 8'd0, 8'd3, 8'd1, 1'b1);
        chk("t1_data", out_data, 32'd5);
        chk("t1_ch", out_channel, 8'd3);
        idle(2, 1'b1);

        // four groups, then a fresh sequence that must overwrite
        step(1'b1, 32'd10, 8'd0, 8'd2, 8'd4, 1'b0);
        step(1'b1, 32'hFFFF_FFFD, 8'd1, 8'd2, 8'd4, 1'b0);
        step(1'b1, 32'd7, 8'd2, 8'd2, 8'd4, 1'b0);
        chk("t2_no_early", out_valid, 1'b0);
        step(1'b1, 32'd1, 8'd3, 8'd2, 8'd4, 1'b0);
        chk("t2_sum", out_data, 32'd15);
        chk("t2_ch", out_channel, 8'd2);
        for (int i = 0; i < 4; i++) step(1'b1, 32'd4, 8'(i), 8'd2, 8'd4, i == 0);
        chk("t2_sum2", out_data, 32'd16);
        idle(2, 1'b1);

        // interleaved channels
        step(1'b1, 32'd1, 8'd0, 8'd0, 8'd2, 1'b0);
        step(1'b1, 32'd100, 8'd0, 8'd1, 8'd2, 1'b0);
        step(1'b1, 32'd2, 8'd1, 8'd0, 8'd2, 1'b0);
        step(1'b1, 32'd200, 8'd1, 8'd1, 8'd2, 1'b0);
        chk("t3_first", {out_data, out_channel}, {32'd3, 8'd0});
        step(1'b0, 32'd0, 8'd0, 8'd0, 8'd2, 1'b1);
        chk("t3_second", {out_data, out_channel}, {32'd300, 8'd1});
        idle(2, 1'b1);

        // upstream obeying issue_ready with a PIPE-deep PE in between
        do_reset();
        for (int i = 0; i < PIPE; i++) pend[i] = 1'b0;
        n_issued  = 0;
        n_arrived = 0;
        for (int c = 0; c < 30; c++) begin
            bit issue;
            bit arrive;
            issue  = issue_ready;
            arrive = pend[0];
            for (int i = 0; i < PIPE - 1; i++) pend[i] = pend[i+1];
            pend[PIPE-1] = issue;
            if (issue) n_issued++;
            step(arrive, 32'(1000 + n_arrived), 8'd0, 8'(n_arrived % OCP), 8'd1, 1'b0);
            if (arrive) n_arrived++;
        end
        chk("t4_issued", n_issued, 8);
        chk("t4_full_valid", out_valid, 1'b1);
        n_dut_pops = 0;
        idle(10, 1'b1);
        chk("t4_drained", n_dut_pops, 8);

        // overflow: nine finals with no drain
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 32'(200 + i), 8'd0, 8'(i), 8'd0, 1'b0);
        chk("t5_overflow", overflow, 1'b1);
        chk("t5_head", out_data, 32'd200);
        idle(10, 1'b1);
        chk("t5_sticky", overflow, 1'b1);

        // reset mid-sequence discards the partial sum
        do_reset();
        step(1'b1, 32'd50, 8'd0, 8'd5, 8'd2, 1'b0);
        do_reset();
        step(1'b1, 32'd1, 8'd0, 8'd5, 8'd2, 1'b0);
        step(1'b1, 32'd7, 8'd1, 8'd5, 8'd2, 1'b0);
        chk("t6_sum", {out_data, out_channel}, {32'd8, 8'd5});
        idle(2, 1'b1);

        // negative single-group sum
        step(1'b1, 32'hFFFF_FFF0, 8'd0, 8'd1, 8'd1, 1'b0);
`ifdef PSUM_COLLECTOR_RELU_EN
        chk("relu_clip", out_data, 32'd0);
`else
        chk("neg_pass", out_data, 32'hFFFF_FFF0);
`endif
        idle(2, 1'b1);

        // randomized legal group sequences, interleaved across entries
        do_reset();
        for (int ph = 0; ph < 5; ph++) begin
            grp = 8'($urandom_range(0, 5));
            g   = (grp == 0) ? 1 : int'(grp);
            for (int i = 0; i < OCP; i++) next_in[i] = 0;
            for (int s = 0; s < 150; s++) begin
                if ($urandom_range(0, 3) != 0) begin
                    e = $urandom_range(0, OCP - 1);
                    if (next_in[e] == 0) seq_osel[e] = 8'(e + OCP * $urandom_range(0, 31));
                    step(1'b1, $urandom, 8'(next_in[e]), seq_osel[e], grp, $urandom_range(0, 3) != 0);
                    next_in[e] = (next_in[e] + 1) % g;
                end else begin
                    step(1'b0, $urandom, 8'd0, 8'd0, grp, $urandom_range(0, 3) != 0);
                end
            end
        end
        idle(DEPTH + 2, 1'b1);
        chk("final_empty", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
